ddr_rd_arbiter: RTL and testbench

- Shares the single AXI4 DDR read channel (master side of the AXI bridge) between N read requesters, e.g. several seed-extension memory interfaces.
- Uses round-robin arbitration and allows one outstanding burst at a time.
- Issues a fixed-length burst for the granted requester, counts the returned beats, and routes each beat back to the owner.
- Sits between the requesters and the AXI bridge slave port.

---
 rtl/ddr_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 36 +++
 rtl/ddr_rd_arbiter.sv | 138 +++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR read-channel arbiter: state encoding,
// default geometry and an index-width helper.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 512;
  localparam int DEF_BEATS  = 8;

  // Width of an index or counter over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick
  import ddr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             any_o,
  output logic [PTR_W-1:0] idx_o
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N);

  logic [N-1:0]   rot;
  logic [PTR_W:0] sum;
  logic [PTR_W:0] wrap;

  assign any_o = |req_i;

  // Rotate so that ptr lands on bit 0, then scan downward so the closest hit wins.
  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    idx_o = {PTR_W{1'b0}};
    sum   = {(PTR_W+1){1'b0}};
    wrap  = {(PTR_W+1){1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      sum   = {1'b0, ptr_i} + (PTR_W+1)'(k);
      wrap  = (sum >= N_EXT) ? (sum - N_EXT) : sum;
      idx_o = rot[k] ? PTR_W'(wrap) : idx_o;
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between N_REQ requesters,
// one fixed-length burst outstanding at a time, beats routed back to the owner.
module ddr_rd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_arvalid,
  input  logic [N_REQ*ADDR_W-1:0] req_araddr,
  output logic [N_REQ-1:0]        req_arready,
  output logic [N_REQ-1:0]        req_rvalid,
  output logic [DATA_W-1:0]       req_rdata,
  output logic                    m_arvalid,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [7:0]              m_arlen,
  input  logic                    m_arready,
  input  logic                    m_rvalid,
  input  logic [DATA_W-1:0]       m_rdata,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    err_unexp
);

  localparam int PTR_W = idx_w(N_REQ);
  localparam int CNT_W = idx_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(N_REQ - 1);
  localparam logic [7:0]       ARLEN     = 8'(BEATS - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e          state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PTR_W-1:0]    grant_q;
  logic                arvalid_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [7:0]          arlen_q;
  logic [N_REQ-1:0]    arready_q;
  logic [N_REQ-1:0]    rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                err_q;

  logic                pick_any;
  logic [PTR_W-1:0]    pick_idx;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (req_arvalid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      grant_q   <= {PTR_W{1'b0}};
      arvalid_q <= 1'b0;
      araddr_q  <= {ADDR_W{1'b0}};
      arlen_q   <= 8'd0;
      arready_q <= {N_REQ{1'b0}};
      rvalid_q  <= {N_REQ{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      arready_q <= {N_REQ{1'b0}};
      rvalid_q  <= {N_REQ{1'b0}};
      case (state_q)
        IDLE: begin
          if (m_rvalid) begin
            err_q <= 1'b1;
          end
          if (pick_any) begin
            grant_q   <= pick_idx;
            araddr_q  <= req_araddr[int'(pick_idx)*ADDR_W +: ADDR_W];
            arlen_q   <= ARLEN;
            arvalid_q <= 1'b1;
            arready_q <= ONE_HOT0 << pick_idx;
            busy_q    <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (m_rvalid) begin
            err_q <= 1'b1;
          end
          if (arvalid_q && m_arready) begin
            arvalid_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (m_rvalid) begin
            rvalid_q[grant_q] <= 1'b1;
            rdata_q           <= m_rdata;
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= {CNT_W{1'b0}};
              busy_q  <= 1'b0;
              state_q <= IDLE;
              ptr_q   <= (grant_q == LAST_REQ) ? {PTR_W{1'b0}} : grant_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign req_arready = arready_q;
  assign req_rvalid  = rvalid_q;
  assign req_rdata   = rdata_q;
  assign m_arvalid   = arvalid_q;
  assign m_araddr    = araddr_q;
  assign m_arlen     = arlen_q;
  assign grant_id    = 3'(grant_q);
  assign busy        = busy_q;
  assign err_unexp   = err_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Table-driven bench for ddr_rd_arbiter with a scoreboard queue for returned beats.
module tb_ddr_rd_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 512;
  localparam int BEATS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_arvalid;
  logic [N*AW-1:0] req_araddr;
  logic [N-1:0]    req_arready;
  logic [N-1:0]    req_rvalid;
  logic [DW-1:0]   req_rdata;
  logic            m_arvalid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic            m_arready;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic [2:0]      grant_id;
  logic            busy;
  logic            err_unexp;

  always #5 clk = ~clk;

  ddr_rd_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arready(req_arready),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .grant_id(grant_id), .busy(busy), .err_unexp(err_unexp)
  );

  typedef struct {
    logic [N-1:0] req;
    int           exp_grant;
    int           ar_delay;
    int           gap;
  } vec_t;

  typedef struct {
    logic [N-1:0]  rv;
    logic [DW-1:0] d;
    time           t;
  } beat_t;

  vec_t          vecs[15];
  beat_t         exp_q[$];
  logic [DW-1:0] last_d;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int r, input int i);
    return (32'(r) << 20) | (32'(i) << 12) | 32'h40;
  endfunction

  function automatic logic [DW-1:0] mk_data(input int r, input int b);
    logic [DW-1:0] d;
    for (int j = 0; j < DW / 32; j++) begin
      d[j*32 +: 32] = (32'(r) << 24) | (32'(b) << 16) | 32'(j);
    end
    return d;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_arready"}, 64'(req_arready), 64'(0));
    chk({tag, "_rvalid"}, 64'(req_rvalid), 64'(0));
    chk_data({tag, "_rdata"}, req_rdata, '0);
    chk({tag, "_m_arvalid"}, 64'(m_arvalid), 64'(0));
    chk({tag, "_m_araddr"}, 64'(m_araddr), 64'(0));
    chk({tag, "_m_arlen"}, 64'(m_arlen), 64'(0));
    chk({tag, "_grant_id"}, 64'(grant_id), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_err"}, 64'(err_unexp), 64'(0));
  endtask

  // Present row r's requests, expect the acceptance one cycle later, then retire the winner.
  task automatic issue(input int r);
    int g;
    int wc;
    g = vecs[r].exp_grant;
    for (int i = 0; i < N; i++) req_araddr[i*AW +: AW] = addr_of(r, i);
    req_arvalid = vecs[r].req;
    wc = 0;
    do begin
      @(negedge clk);
      wc++;
    end while (req_arready == '0 && wc < 20);
    chk("accept_latency", 64'(wc), 64'(1));
    chk("arready_onehot", 64'(req_arready), 64'(onehot(g)));
    chk("grant_id", 64'(grant_id), 64'(g));
    chk("m_arvalid_set", 64'(m_arvalid), 64'(1));
    chk("m_araddr", 64'(m_araddr), 64'(addr_of(r, g)));
    chk("m_arlen", 64'(m_arlen), 64'(BEATS - 1));
    chk("busy_addr", 64'(busy), 64'(1));
    req_arvalid[g] = 1'b0;
  endtask

  task automatic handshake(input int r);
    int g;
    g = vecs[r].exp_grant;
    for (int k = 0; k < vecs[r].ar_delay; k++) begin
      @(negedge clk);
      chk("arvalid_hold", 64'(m_arvalid), 64'(1));
      chk("araddr_hold", 64'(m_araddr), 64'(addr_of(r, g)));
      chk("arready_pulse", 64'(req_arready), 64'(0));
    end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    chk("arvalid_clr", 64'(m_arvalid), 64'(0));
    chk("arready_single", 64'(req_arready), 64'(0));
    chk("busy_data", 64'(busy), 64'(1));
  endtask

  task automatic send_beats(input int r, input int nb, input int gap, input bit fin);
    beat_t e;
    for (int b = 0; b < nb; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = mk_data(r, b);
      e.rv = onehot(vecs[r].exp_grant);
      e.d  = mk_data(r, b);
      e.t  = $time;
      exp_q.push_back(e);
      @(negedge clk);
      m_rvalid = 1'b0;
      if (b < nb - 1) begin
        chk("busy_mid", 64'(busy), 64'(1));
        repeat (gap) @(negedge clk);
      end
    end
    if (fin) begin
      chk("busy_done", 64'(busy), 64'(0));
      chk("arvalid_done", 64'(m_arvalid), 64'(0));
    end
  endtask

  task automatic run_row(input int r);
    issue(r);
    handshake(r);
    send_beats(r, BEATS, vecs[r].gap, 1'b1);
  endtask

  // Scoreboard monitor: every returned beat must match the oldest expected one.
  initial begin
    beat_t e;
    last_d = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        exp_q.delete();
        last_d = '0;
      end else if (req_rvalid != '0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rvalid_owner", 64'(req_rvalid), 64'(e.rv));
        chk_data("rdata", req_rdata, e.d);
        last_d = e.d;
      end else begin
        chk("rvalid_none", 64'(req_rvalid), 64'(0));
        chk_data("rdata_hold", req_rdata, last_d);
        if (exp_q.size() > 0 && exp_q[0].t < $time) begin
          e = exp_q.pop_front();
          chk("beat_late", 64'(req_rvalid), 64'(e.rv));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    rst         = 1'b0;
    req_arvalid = '0;
    req_araddr  = '0;
    m_arready   = 1'b0;
    m_rvalid    = 1'b0;
    m_rdata     = '0;

    vecs[0]  = '{req: 4'b1111, exp_grant: 0, ar_delay: 0, gap: 0};
    vecs[1]  = '{req: 4'b1111, exp_grant: 1, ar_delay: 1, gap: 0};
    vecs[2]  = '{req: 4'b1111, exp_grant: 2, ar_delay: 0, gap: 1};
    vecs[3]  = '{req: 4'b1111, exp_grant: 3, ar_delay: 2, gap: 0};
    vecs[4]  = '{req: 4'b1111, exp_grant: 0, ar_delay: 0, gap: 0};
    vecs[5]  = '{req: 4'b0010, exp_grant: 1, ar_delay: 0, gap: 0};
    vecs[6]  = '{req: 4'b0100, exp_grant: 2, ar_delay: 1, gap: 0};
    vecs[7]  = '{req: 4'b1001, exp_grant: 3, ar_delay: 0, gap: 0};
    vecs[8]  = '{req: 4'b1001, exp_grant: 0, ar_delay: 0, gap: 1};
    vecs[9]  = '{req: 4'b0001, exp_grant: 0, ar_delay: 0, gap: 0};
    vecs[10] = '{req: 4'b1100, exp_grant: 2, ar_delay: 0, gap: 0};
    vecs[11] = '{req: 4'b1000, exp_grant: 3, ar_delay: 5, gap: 2};
    vecs[12] = '{req: 4'b0010, exp_grant: 1, ar_delay: 0, gap: 0};
    vecs[13] = '{req: 4'b0100, exp_grant: 2, ar_delay: 0, gap: 0};
    vecs[14] = '{req: 4'b1001, exp_grant: 0, ar_delay: 0, gap: 0};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 12; r++) run_row(r);

    // Beat with no burst outstanding is dropped and flagged.
    chk("err_before", 64'(err_unexp), 64'(0));
    m_rvalid = 1'b1;
    m_rdata  = mk_data(99, 0);
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("err_set", 64'(err_unexp), 64'(1));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("arvalid_idle", 64'(m_arvalid), 64'(0));
    run_row(12);
    chk("err_sticky", 64'(err_unexp), 64'(1));

    // Abandon a burst after three beats with an asynchronous reset.
    issue(13);
    handshake(13);
    send_beats(13, 3, 0, 1'b0);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("err_after_rst", 64'(err_unexp), 64'(0));
    m_rvalid = 1'b1;
    m_rdata  = mk_data(98, 3);
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("err_stale", 64'(err_unexp), 64'(1));
    run_row(14);

    @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
